// File: rtl/countdown_timer_pkg.sv
// Shared counter/timer definitions: the state encoding used by the countdown timer
// and reused by later counter and timer blocks.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_EXPIRED = 2'd2
   } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable synchronous down counter with a one-cycle terminal-count pulse and an
// optional periodic reload mode, for timeout and interval generation.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [SIZE-1:0] load_value,
   input  logic            enable,
   input  logic            auto_reload,
   output logic [SIZE-1:0] value,
   output logic            zero,
   output logic            tc,
   output logic            running
);

   timer_state_t    state, state_nxt;
   logic [SIZE-1:0] value_nxt;
   logic [SIZE-1:0] reload_q, reload_nxt;
   logic            tc_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         value    <= '0;
         reload_q <= '0;
         tc       <= 1'b0;
      end else begin
         state    <= state_nxt;
         value    <= value_nxt;
         reload_q <= reload_nxt;
         tc       <= tc_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      value_nxt  = value;
      reload_nxt = reload_q;
      tc_nxt     = 1'b0;

      if (load) begin
         value_nxt  = load_value;
         reload_nxt = load_value;
         state_nxt  = (load_value != '0) ? ST_RUNNING : ST_IDLE;
      end else if (state == ST_RUNNING && enable) begin
         // RUNNING never holds 0, so the terminal step is the only place 0 is reached.
         if (value == SIZE'(1)) begin
            tc_nxt = 1'b1;
            if (auto_reload) begin
               value_nxt = reload_q;
            end else begin
               value_nxt = '0;
               state_nxt = ST_EXPIRED;
            end
         end else begin
            value_nxt = value - SIZE'(1);
         end
      end
   end

   assign zero    = (value == '0);
   assign running = (state == ST_RUNNING);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-scenario tasks push expected
// per-cycle outputs to a scoreboard and compare them after each clock edge.
module tb_countdown_timer;

   localparam int SIZE = 8;

   typedef struct {
      logic [SIZE-1:0] value;
      logic            tc;
      logic            running;
      logic            zero;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            load = 1'b0;
   logic [SIZE-1:0] load_value = '0;
   logic            enable = 1'b0;
   logic            auto_reload = 1'b0;
   logic [SIZE-1:0] value;
   logic            zero;
   logic            tc;
   logic            running;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   countdown_timer #(.SIZE(SIZE)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .auto_reload(auto_reload),
      .value      (value),
      .zero       (zero),
      .tc         (tc),
      .running    (running)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, queue the expected post-edge outputs, then
   // pop and compare them 1 time unit after the rising edge.
   task automatic tick(input string tag, input logic r, input logic ld,
                       input logic [SIZE-1:0] lv, input logic en, input logic ar,
                       input logic [SIZE-1:0] ev, input logic etc, input logic erun);
      exp_t e;
      @(negedge clk);
      reset       = r;
      load        = ld;
      load_value  = lv;
      enable      = en;
      auto_reload = ar;
      sb.push_back('{value: ev, tc: etc, running: erun, zero: (ev == '0)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({value, tc, running, zero} !== {e.value, e.tc, e.running, e.zero}) begin
         miscompares++;
         $display("FAIL %s: got value=%0d tc=%b running=%b zero=%b, expected value=%0d tc=%b running=%b zero=%b",
                  tag, value, tc, running, zero, e.value, e.tc, e.running, e.zero);
      end
   endtask

   task automatic test_reset();
      tick("reset", 1, 0, 0, 0, 0, 0, 0, 0);
      tick("reset_hold_enable", 0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_one_shot();
      tick("oneshot_load", 0, 1, 5, 1, 0, 5, 0, 1);
      tick("oneshot_4", 0, 0, 0, 1, 0, 4, 0, 1);
      tick("oneshot_3", 0, 0, 0, 1, 0, 3, 0, 1);
      tick("oneshot_2", 0, 0, 0, 1, 0, 2, 0, 1);
      tick("oneshot_1", 0, 0, 0, 1, 0, 1, 0, 1);
      tick("oneshot_tc", 0, 0, 0, 1, 0, 0, 1, 0);
      tick("expired_hold_a", 0, 0, 0, 1, 0, 0, 0, 0);
      tick("expired_hold_b", 0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_periodic();
      tick("periodic_load", 0, 1, 3, 1, 1, 3, 0, 1);
      for (int p = 0; p < 3; p++) begin
         tick("periodic_2", 0, 0, 0, 1, 1, 2, 0, 1);
         tick("periodic_1", 0, 0, 0, 1, 1, 1, 0, 1);
         tick("periodic_reload", 0, 0, 0, 1, 1, 3, 1, 1);
      end
   endtask

   task automatic test_toggle_enable();
      tick("toggle_load", 0, 1, 4, 0, 0, 4, 0, 1);
      tick("toggle_en1", 0, 0, 0, 1, 0, 3, 0, 1);
      tick("toggle_hold1", 0, 0, 0, 0, 0, 3, 0, 1);
      tick("toggle_en2", 0, 0, 0, 1, 0, 2, 0, 1);
      tick("toggle_hold2", 0, 0, 0, 0, 0, 2, 0, 1);
      tick("toggle_en3", 0, 0, 0, 1, 0, 1, 0, 1);
      tick("toggle_hold3", 0, 0, 0, 0, 0, 1, 0, 1);
      tick("toggle_tc", 0, 0, 0, 1, 0, 0, 1, 0);
      tick("toggle_after", 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_load_wins();
      tick("lw_load", 0, 1, 6, 0, 0, 6, 0, 1);
      tick("lw_5", 0, 0, 0, 1, 0, 5, 0, 1);
      tick("lw_4", 0, 0, 0, 1, 0, 4, 0, 1);
      tick("lw_3", 0, 0, 0, 1, 0, 3, 0, 1);
      tick("lw_2", 0, 0, 0, 1, 0, 2, 0, 1);
      tick("lw_reload10", 0, 1, 10, 1, 0, 10, 0, 1);
      tick("lw_9", 0, 0, 0, 1, 0, 9, 0, 1);
      tick("lw_8", 0, 0, 0, 1, 0, 8, 0, 1);
      // load coincident with the terminal step suppresses tc
      tick("lw_term_load1", 0, 1, 1, 0, 0, 1, 0, 1);
      tick("lw_term_load7", 0, 1, 7, 1, 0, 7, 0, 1);
      tick("lw_term_6", 0, 0, 0, 1, 0, 6, 0, 1);
   endtask

   task automatic test_reset_dominates();
      tick("rd_load", 0, 1, 8, 0, 0, 8, 0, 1);
      tick("rd_7", 0, 0, 0, 1, 0, 7, 0, 1);
      tick("rd_6", 0, 0, 0, 1, 0, 6, 0, 1);
      tick("rd_5", 0, 0, 0, 1, 0, 5, 0, 1);
      tick("rd_reset_load", 1, 1, 9, 1, 0, 0, 0, 0);
      tick("rd_enable_only", 0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_boundaries();
      tick("zero_load", 0, 1, 0, 1, 0, 0, 0, 0);
      tick("zero_enable", 0, 0, 0, 1, 1, 0, 0, 0);
      tick("one_load", 0, 1, 1, 1, 1, 1, 0, 1);
      for (int k = 0; k < 3; k++)
         tick("one_tc_every", 0, 0, 0, 1, 1, 1, 1, 1);
      tick("one_hold", 0, 0, 0, 0, 1, 1, 0, 1);
      // auto_reload only matters on the terminal edge
      tick("ar_load", 0, 1, 3, 0, 0, 3, 0, 1);
      tick("ar_2", 0, 0, 0, 1, 1, 2, 0, 1);
      tick("ar_1", 0, 0, 0, 1, 0, 1, 0, 1);
      tick("ar_term", 0, 0, 0, 1, 1, 3, 1, 1);
      tick("max_load", 0, 1, 255, 0, 0, 255, 0, 1);
      tick("max_dec", 0, 0, 0, 1, 0, 254, 0, 1);
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_toggle_enable();
      test_load_wins();
      test_reset_dominates();
      test_boundaries();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
